ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
// - PS/2 host-to-device byte transmitter: the send side of the keyboard link,
//   complementing the existing keyboard receive path.
//   Uses: LED command 0xED, reset 0xFF, set typematic rate.
// - Drives open-drain PS2_CLK/PS2_DAT through active-high pull-low enables.
// - busy output lets top level gate the keyboard receiver during a send.
// PARAMETERS
// - INHIBIT_CYCLES  6000    clock cycles CLK held low before start (120us @ 50MHz)
// - TIMEOUT_CYCLES  750000  max cycles from CLK release to ACK (15ms @ 50MHz)
// - MAX_RETRIES     2       extra attempts after failure; used only with PS2_TX_RETRY_EN
// PORTS
// - clock       in   1  system clock (CLOCK_50 domain)
// - reset       in   1  synchronous, active-high
// - tx_valid    in   1  request to send tx_data
// - tx_data     in   8  byte to send, LSB first
// - tx_ready    out  1  high in IDLE; transfer accepted when tx_valid & tx_ready
// - ps2_clk_in  in   1  raw PS2_CLK pad level (async)
// - ps2_dat_in  in   1  raw PS2_DAT pad level (async)
// - ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release (hi-Z)
// - ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release
// - busy        out  1  high in every state except IDLE
// - tx_done     out  1  one-cycle pulse when the transfer ends (success or failure)
// - tx_ack_ok   out  1  valid with tx_done: 1 = device ACKed, 0 = NACK/timeout
// BEHAVIOUR
// - Reset: state IDLE, tx_ready=1, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, tx_done=0,
//   tx_ack_ok=0, counters 0. Reset mid-transfer releases both lines on the next edge.
// - Inputs pass through 2-flop synchronizers. A falling edge (fe) is prev=1, now=0
//   on the synchronized CLK. All bit timing uses fe only.
// - Accept: on tx_valid & tx_ready, latch tx_data and parity = ~^tx_data (odd parity).
//   Then go to INHIBIT. tx_valid while busy is ignored (no queueing).
// - INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles.
//   On the last cycle set dat_oe=1 (start bit), then go to START.
// - START: clk_oe=0, dat_oe=1. Clear the timeout counter and fe count.
// - Bits, driven after each fe (fe count n=1..11):
//   - n=1..8: dat_oe = ~data[n-1]
//   - n=9: dat_oe = ~parity
//   - n=10: dat_oe=0 (stop bit = 1)
//   - n=11: sample synced DAT; ACK = (DAT==0)
// - WAIT_IDLE: after n=11, wait until synced CLK=1 and DAT=1, then go to DONE.
// - DONE: one cycle. Pulse tx_done with tx_ack_ok = ACK, then go to IDLE.
// - Timeout: counter runs from entry into START through n=11.
//   If it reaches TIMEOUT_CYCLES: release both lines, tx_done=1, tx_ack_ok=0,
//   go to IDLE without waiting for idle lines.
// - Simultaneous fe and timeout in the same cycle: timeout wins.
// - Counter widths: $clog2(param+1). fe count is 4 bits and saturates at 11.
// - Latency: accept -> CLK low next cycle; tx_ready low from the cycle after accept
//   until the cycle after DONE.
// CONFIGURATION
// - PS2_TX_RETRY_EN defined: on NACK or timeout, reload the latched byte and re-enter
//   INHIBIT, up to MAX_RETRIES extra attempts. tx_done pulses once, only after success
//   or final failure. busy stays high across retries.
// - PS2_TX_RETRY_EN undefined: every failure ends the transfer immediately with
//   tx_done=1, tx_ack_ok=0. MAX_RETRIES is ignored.
// TESTING (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, device model clocks ~40-cycle period)
// - Reset: hold reset 3 cycles -> clk_oe=0, dat_oe=0, tx_ready=1, busy=0, tx_done=0.
// - Send 0xED with ACK -> clk_oe high exactly 20 cycles; device samples bits 1,0,1,1,0,1,1,1,
//   parity=1, stop=1; single tx_done with tx_ack_ok=1.
// - Parity: 0x01 -> parity 0; 0xFF -> 1; 0x00 -> 1; all ACKed.
// - NACK: device leaves DAT high at bit 11 -> tx_done=1, tx_ack_ok=0, returns to IDLE
//   after lines go high.
// - Timeout: device never clocks -> tx_done at 2000 cycles after START,
//   tx_ack_ok=0, both lines released.
// - Busy/reset: tx_valid pulsed mid-transfer is ignored (one transfer only);
//   reset at bit 4 releases lines next edge, and no tx_done fires.
// - Retry (PS2_TX_RETRY_EN, MAX_RETRIES=2): NACK twice then ACK -> 3 inhibit phases,
//   one tx_done with tx_ack_ok=1; 3 NACKs give tx_ack_ok=0.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter driving open-drain CLK/DAT pull-low enables.
// Optional retry on NACK/timeout is enabled by defining PS2_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
`ifdef PS2_TX_RETRY_EN
  ,
  parameter int MAX_RETRIES = 2
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, XFER, WAIT_IDLE, DONE} state_t;
  state_t state, state_n;
  logic [1:0] clk_sync, dat_sync;
  logic clk_prev, clk_s, dat_s, fe;
  logic [7:0] data;
  logic parity, ack, can_retry;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic [3:0] fcnt;
  logic inhibit_end, timeout, last_fe, lines_idle;
  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];
  assign fe = clk_prev & ~clk_s;
  assign inhibit_end = state == INHIBIT && icnt == IW'(INHIBIT_CYCLES - 1);
  assign timeout = state == XFER && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign last_fe = state == XFER && fe && fcnt == 4'd10;
  assign lines_idle = clk_s && dat_s;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
      data <= '0;
      parity <= 1'b0;
      ack <= 1'b0;
      icnt <= '0;
      tcnt <= '0;
      fcnt <= '0;
    end else begin
      state <= state_n;
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_s;
      if (state == IDLE && tx_valid) begin
        data <= tx_data;
        parity <= ~^tx_data;
      end
      icnt <= (state == INHIBIT) ? icnt + IW'(1) : '0;
      tcnt <= (state == XFER) ? tcnt + TW'(1) : '0;
      fcnt <= (state != XFER) ? 4'd0 : (fe && fcnt != 4'd11) ? fcnt + 4'd1 : fcnt;
      ack <= timeout ? 1'b0 : last_fe ? ~dat_s : ack;
    end
  end
`ifdef PS2_TX_RETRY_EN
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RW-1:0] rcnt;
  assign can_retry = rcnt != RW'(MAX_RETRIES);
  always_ff @(posedge clock) begin
    if (reset || state == IDLE) rcnt <= '0;
    else if (state != INHIBIT && state_n == INHIBIT) rcnt <= rcnt + RW'(1);
  end
`else
  assign can_retry = 1'b0;
`endif
  // Timeout is checked before the fe so it wins when both land in one cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = tx_valid ? INHIBIT : IDLE;
      INHIBIT:   state_n = inhibit_end ? XFER : INHIBIT;
      XFER:      state_n = timeout ? (can_retry ? INHIBIT : DONE) : last_fe ? WAIT_IDLE : XFER;
      WAIT_IDLE: state_n = !lines_idle ? WAIT_IDLE : (!ack && can_retry) ? INHIBIT : DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    tx_ready = state == IDLE;
    busy = state != IDLE;
    tx_done = state == DONE;
    tx_ack_ok = state == DONE && ack;
    ps2_clk_oe = state == INHIBIT;
    ps2_dat_oe = inhibit_end || (state == XFER && (fcnt == 4'd0 ? 1'b1 :
                 fcnt <= 4'd8 ? ~data[3'(fcnt - 4'd1)] : fcnt == 4'd9 ? ~parity : 1'b0));
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  logic clock = 1'b0, reset = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_ack_ok;
  logic dev_clk_lo = 1'b0, dev_dat_lo = 1'b0;
  logic clk_line, dat_line;
  assign clk_line = ~(ps2_clk_oe | dev_clk_lo);
  assign dat_line = ~(ps2_dat_oe | dev_dat_lo);
  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
    .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .ps2_clk_in(clk_line), .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
    .tx_done(tx_done), .tx_ack_ok(tx_ack_ok));
  always #5 clock = ~clock;
  int cyc = 0, done_cnt = 0, inh_cnt = 0, oe_cyc = 0;
  int acc_cyc = 0, inh_cyc = 0, xfer_cyc = 0, done_cyc = 0;
  logic last_ack = 1'b0, done_oe = 1'b0, prev_oe = 1'b0;
  always @(negedge clock) begin
    cyc <= cyc + 1;
    prev_oe <= ps2_clk_oe;
    if (ps2_clk_oe) oe_cyc <= oe_cyc + 1;
    if (ps2_clk_oe && !prev_oe) begin
      inh_cnt <= inh_cnt + 1;
      inh_cyc <= cyc;
    end
    if (!ps2_clk_oe && prev_oe) xfer_cyc <= cyc;
    if (tx_valid && tx_ready) acc_cyc <= cyc;
    if (tx_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      last_ack <= tx_ack_ok;
      done_oe <= ps2_clk_oe | ps2_dat_oe;
    end
  end
  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic start(input logic [7:0] d);
    @(posedge clock); #1 tx_valid = 1'b1; tx_data = d;
    @(posedge clock); #1 tx_valid = 1'b0;
  endtask
  task automatic wait_start_bit(output logic seen);
    int n = 0;
    while (!(clk_line && !dat_line) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    seen = n < 1000;
    check("start_bit", {31'd0, seen}, 32'd1);
  endtask
  task automatic pulse;
    dev_clk_lo = 1'b1;
    repeat (20) @(negedge clock);
    dev_clk_lo = 1'b0;
    repeat (20) @(negedge clock);
  endtask
  // Device samples each host bit just before the next falling edge it generates.
  task automatic device(input logic ack_en, output logic [9:0] bits);
    logic seen;
    bits = '0;
    wait_start_bit(seen);
    if (!seen) return;
    repeat (20) @(negedge clock);
    for (int i = 1; i <= 11; i++) begin
      if (i >= 2) bits[i-2] = dat_line;
      if (i == 11 && ack_en) begin
        dev_dat_lo = 1'b1;
        repeat (5) @(negedge clock);
      end
      pulse();
    end
    dev_dat_lo = 1'b0;
  endtask
  task automatic wait_done(input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin
      @(posedge clock);
      n++;
    end
    check("done_seen", {31'd0, n < limit}, 32'd1);
    repeat (2) @(posedge clock);
  endtask
  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       ack_ok;
  } vec_t;
  vec_t vecs[5];
  logic [9:0] bits;
  logic seen;
  int base_d, base_o, base_i;
  initial begin
    vecs[0] = '{8'hED, 1'b1, 1'b1};
    vecs[1] = '{8'h01, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h07, 1'b0, 1'b1};
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
    check("rst_ready", {31'd0, tx_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, tx_done}, 0);
    check("rst_ack_ok", {31'd0, tx_ack_ok}, 0);
    repeat (10) @(posedge clock);
    foreach (vecs[k]) begin
      base_d = done_cnt;
      base_o = oe_cyc;
      start(vecs[k].data);
      device(1'b1, bits);
      wait_done(base_d, 500);
      check("byte", {24'd0, bits[7:0]}, {24'd0, vecs[k].data});
      check("parity", {31'd0, bits[8]}, {31'd0, vecs[k].par});
      check("stop", {31'd0, bits[9]}, 1);
      check("done_once", done_cnt - base_d, 1);
      check("ack_ok", {31'd0, last_ack}, {31'd0, vecs[k].ack_ok});
      check("inhibit_len", oe_cyc - base_o, 20);
      check("accept_lat", inh_cyc - acc_cyc, 1);
      check("ready_after", {31'd0, tx_ready}, 1);
      repeat (20) @(posedge clock);
    end
    base_d = done_cnt;
    base_i = inh_cnt;
    start(8'h5A);
    repeat (3) @(posedge clock);
    #1 tx_valid = 1'b1; tx_data = 8'h11;
    @(negedge clock);
    check("busy_mid", {31'd0, busy}, 1);
    check("ready_mid", {31'd0, tx_ready}, 0);
    repeat (3) @(posedge clock);
    #1 tx_valid = 1'b0;
    device(1'b1, bits);
    wait_done(base_d, 500);
    check("busy_byte", {24'd0, bits[7:0]}, 32'h5A);
    repeat (300) @(posedge clock);
    check("busy_one_done", done_cnt - base_d, 1);
    check("busy_one_inh", inh_cnt - base_i, 1);
    base_d = done_cnt;
    start(8'h00);
    wait_start_bit(seen);
    repeat (20) @(negedge clock);
    repeat (4) pulse();
    check("bit4_dat_oe", {31'd0, ps2_dat_oe}, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rstmid_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("rstmid_dat_oe", {31'd0, ps2_dat_oe}, 0);
    check("rstmid_ready", {31'd0, tx_ready}, 1);
    reset = 1'b0;
    repeat (200) @(posedge clock);
    check("rstmid_no_done", done_cnt - base_d, 0);
`ifndef PS2_TX_RETRY_EN
    base_d = done_cnt;
    start(8'hA5);
    device(1'b0, bits);
    wait_done(base_d, 500);
    check("nack_byte", {24'd0, bits[7:0]}, 32'hA5);
    check("nack_parity", {31'd0, bits[8]}, 1);
    check("nack_ack_ok", {31'd0, last_ack}, 0);
    check("nack_done_once", done_cnt - base_d, 1);
    check("nack_ready", {31'd0, tx_ready}, 1);
    repeat (20) @(posedge clock);
    base_d = done_cnt;
    start(8'h3C);
    wait_done(base_d, 3000);
    check("tmo_latency", done_cyc - xfer_cyc, 2000);
    check("tmo_ack_ok", {31'd0, last_ack}, 0);
    check("tmo_lines", {31'd0, done_oe}, 0);
    check("tmo_ready", {31'd0, tx_ready}, 1);
`else
    base_d = done_cnt;
    base_i = inh_cnt;
    start(8'h42);
    device(1'b0, bits);
    device(1'b0, bits);
    device(1'b1, bits);
    wait_done(base_d, 500);
    check("retry_inh", inh_cnt - base_i, 3);
    check("retry_done", done_cnt - base_d, 1);
    check("retry_ack_ok", {31'd0, last_ack}, 1);
    check("retry_byte", {24'd0, bits[7:0]}, 32'h42);
    repeat (20) @(posedge clock);
    base_d = done_cnt;
    base_i = inh_cnt;
    start(8'h42);
    repeat (3) device(1'b0, bits);
    wait_done(base_d, 500);
    check("fail_inh", inh_cnt - base_i, 3);
    check("fail_done", done_cnt - base_d, 1);
    check("fail_ack_ok", {31'd0, last_ack}, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
